weight_bram_reader: RTL and testbench
=====================================

# weight_bram_reader

Sequencing read master for one single-port weight BRAM of the ANN layer, e.g. a 28-entry x 16-bit Weight_x_y_z memory. On START it walks the memory from address 0 to DEPTH-1 and delivers each signed weight to the MAC datapath as a valid/ready stream, absorbing the BRAM's falling-edge read timing. It sits between one weight BRAM and one neuron accumulator. A compile-time option adds a streaming load path that rewrites the memory contents.

## Interface
- DEPTH, 28, number of weight words per pass
- AW, 5, address width, equal to $clog2(DEPTH)
- DW, 16, weight width (two's complement)

- CLK  in  1  single clock, rising edge; the BRAM is clocked by the same CLK on its falling edge
- RST_N  in  1  asynchronous, active-low reset
- START  in  1  one-cycle pulse that begins a pass; ignored while BUSY=1
- BUSY  out  1  high from the cycle after START until the cycle DONE pulses
- DONE  out  1  one-cycle pulse after the last beat is accepted
- ADDR  out  AW  BRAM address
- EN  out  1  BRAM enable
- WE  out  1  BRAM write enable
- DI  out  DW  BRAM write data
- DO  in  DW  BRAM read data, updated on the falling edge of CLK
- W_DATA  out  DW  weight to the datapath
- W_VALID  out  1  W_DATA is valid
- W_READY  in  1  datapath accepts the beat
- W_LAST  out  1  marks the beat holding address DEPTH-1

## Operation
- Reset values: ADDR=0, EN=0, WE=0, DI=0, W_DATA=0, W_VALID=0, W_LAST=0, BUSY=0, DONE=0; the FSM enters IDLE and the buffer is empty.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE -> FETCH on START: the read pointer clears to 0.
  - FETCH: EN=1 and ADDR=pointer in every cycle where the buffer count is below 2. The pointer increments on each issued read.
  - FETCH -> DRAIN after the read of DEPTH-1 is issued. The pointer saturates and never addresses DEPTH..2^AW-1.
  - DRAIN -> IDLE on the W_LAST handshake; DONE pulses in the following cycle.
- Buffer: 2-entry FIFO carrying {data, last}.
  - A read issued during cycle t is captured from DO into the FIFO at the rising edge that ends cycle t.
  - A pop occurs on W_VALID && W_READY.
  - A simultaneous push and pop at the same edge keeps the count unchanged.
- The EN decision depends only on registered state (count < 2), never on W_READY, so no combinational path runs from W_READY to the BRAM.
- W_DATA, W_VALID and W_LAST hold stable while W_VALID=1 and W_READY=0.
- WE=0 and DI=0 at all times unless the load path is active.
- A START pulse during BUSY is dropped and has no side effects.
- RST_N asserted mid-pass aborts the pass immediately. The FIFO is flushed, all outputs return to their reset values, and no DONE is issued.

## Timing
- First read: EN rises in the cycle after START is sampled. W_VALID rises one cycle later.
- Throughput: 1 weight per cycle with W_READY held high. With the stream unstalled, a full pass takes DEPTH+2 cycles from START to the W_LAST beat, and DONE follows one cycle after that.
- Backpressure: when W_READY goes low, at most 2 beats are buffered and EN drops once the count reaches 2. Reads resume in the cycle after the first pop.

## Configuration
- WEIGHT_RD_LOAD_EN defined:
  - Adds ports LOAD (in, 1), LD_DATA (in, DW), LD_VALID (in, 1) and LD_READY (out, 1), plus FSM state LOAD.
  - START with LOAD=1 enters LOAD with the pointer at 0.
  - LD_READY=1 while in LOAD. Each LD_VALID beat drives EN=1, WE=1, ADDR=pointer and DI=LD_DATA combinationally in the same cycle, then increments the pointer.
  - After DEPTH beats the FSM returns to IDLE and DONE pulses. No W_* beats are produced during LOAD.
- WEIGHT_RD_LOAD_EN undefined: the LOAD/LD_* ports and the LOAD state are absent, and WE and DI are tied to 0.

## Structure
- Shared package weight_pkg holds:
  - the DEPTH, AW and DW defaults;
  - the FSM state enum (IDLE, FETCH, DRAIN, LOAD);
  - the FIFO entry struct {data, last}.
- One sub-module, weight_skid_fifo: a 2-entry FIFO with push, pop, count, and registered head outputs.

## Test plan
- Free-running pass: memory preloaded with word i = i-14, W_READY=1 -> 28 beats with values -14..13 in order, W_LAST only on value 13, DONE exactly one cycle after it.
- Backpressure: W_READY toggles 1,0,0,1 repeatedly -> no beat lost or duplicated, EN low whenever the count is 2, and ADDR never exceeds 27.
- START during BUSY: second START at cycle 5 -> exactly 28 beats and one DONE.
- Reset mid-pass: RST_N low after beat 10 -> all outputs at reset values, no DONE; a new START restarts from address 0.
- Under WEIGHT_RD_LOAD_EN: load 28 words of 16'h7FFF, 16'h8000 alternating, then run a read pass -> the read stream matches exactly, and WE was high on exactly 28 cycles.

Source files
------------

// File: rtl/weight_pkg.sv
// Shared definitions for the weight BRAM read master: default geometry,
// FSM state encoding and the {data, last} entry carried by the skid FIFO.
package weight_pkg;

  localparam int WEIGHT_DEPTH = 28;
  localparam int WEIGHT_AW    = $clog2(WEIGHT_DEPTH);
  localparam int WEIGHT_DW    = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    LOAD
  } weight_state_t;

  typedef struct packed {
    logic [WEIGHT_DW-1:0] data;
    logic                 last;
  } weight_entry_t;

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry FIFO holding BRAM read results; the head entry and the count
// come straight from registers so the stream outputs are glitch-free.
module weight_skid_fifo
  import weight_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  weight_entry_t din,
  output weight_entry_t head,
  output logic [1:0]    count
);

  weight_entry_t head_reg;
  weight_entry_t tail_reg;
  logic [1:0]    count_reg;

  // The caller never pushes into a full FIFO nor pops an empty one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_reg == 2'd0) head_reg <= din;
          else                   tail_reg <= din;
          count_reg <= count_reg + 2'd1;
        end
        2'b01: begin
          head_reg  <= tail_reg;
          count_reg <= count_reg - 2'd1;
        end
        2'b11: begin
          if (count_reg == 2'd2) begin
            head_reg <= tail_reg;
            tail_reg <= din;
          end else begin
            head_reg <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = head_reg;
  assign count = count_reg;

endmodule

// File: rtl/weight_bram_reader.sv
// Walks one weight BRAM (read on the falling edge) and streams its words out
// as valid/ready beats. Define WEIGHT_RD_LOAD_EN to add the streaming load path.
module weight_bram_reader
  import weight_pkg::*;
#(
  parameter int DEPTH = WEIGHT_DEPTH,
  parameter int AW    = WEIGHT_AW,
  parameter int DW    = WEIGHT_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] addr,
  output logic          en,
  output logic          we,
  output logic [DW-1:0] di,
  input  logic [DW-1:0] bram_do,
  output logic [DW-1:0] w_data,
  output logic          w_valid,
  input  logic          w_ready,
  output logic          w_last
`ifdef WEIGHT_RD_LOAD_EN
  ,
  input  logic          load,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_valid,
  output logic          ld_ready
`endif
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  weight_state_t state_reg, state_next;
  logic [AW-1:0] ptr_reg, ptr_next;
  logic          done_reg, done_next;

  logic          push;
  logic          pop;
  weight_entry_t push_entry;
  weight_entry_t head_entry;
  logic [1:0]    fifo_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      done_reg  <= done_next;
    end
  end

  // EN only looks at registered state, so w_ready never reaches the BRAM.
  always_comb begin
    state_next      = state_reg;
    ptr_next        = ptr_reg;
    done_next       = 1'b0;
    en              = 1'b0;
    we              = 1'b0;
    di              = '0;
    addr            = ptr_reg;
    push            = 1'b0;
    push_entry.data = bram_do;
    push_entry.last = (ptr_reg == LAST_ADDR);
`ifdef WEIGHT_RD_LOAD_EN
    ld_ready        = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        if (start) begin
          ptr_next   = '0;
`ifdef WEIGHT_RD_LOAD_EN
          state_next = load ? LOAD : FETCH;
`else
          state_next = FETCH;
`endif
        end
      end
      FETCH: begin
        if (fifo_count < 2'd2) begin
          en   = 1'b1;
          push = 1'b1;
          if (ptr_reg == LAST_ADDR) state_next = DRAIN;
          else                      ptr_next   = ptr_reg + AW'(1);
        end
      end
      DRAIN: begin
        if (pop && head_entry.last) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
`ifdef WEIGHT_RD_LOAD_EN
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          en = 1'b1;
          we = 1'b1;
          di = ld_data;
          if (ptr_reg == LAST_ADDR) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            ptr_next = ptr_reg + AW'(1);
          end
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  weight_skid_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .head  (head_entry),
    .count (fifo_count)
  );

  assign w_valid = (fifo_count != 2'd0);
  assign w_data  = head_entry.data;
  assign w_last  = w_valid & head_entry.last;
  assign pop     = w_valid & w_ready;
  assign busy    = (state_reg != IDLE);
  assign done    = done_reg;

endmodule

// File: tb/tb_weight_bram_reader.sv
// Scoreboard bench for weight_bram_reader with a falling-edge BRAM model;
// the load-path test runs when WEIGHT_RD_LOAD_EN is defined.
module tb_weight_bram_reader;
  import weight_pkg::*;

  localparam int DEPTH = 28;
  localparam int AW    = 5;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy, done;
  logic [AW-1:0] addr;
  logic          en, we;
  logic [DW-1:0] di;
  logic [DW-1:0] bram_do;
  logic [DW-1:0] w_data;
  logic          w_valid;
  logic          w_ready;
  logic          w_last;
`ifdef WEIGHT_RD_LOAD_EN
  logic          load;
  logic [DW-1:0] ld_data;
  logic          ld_valid;
  logic          ld_ready;
`endif

  weight_bram_reader dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .addr    (addr),
    .en      (en),
    .we      (we),
    .di      (di),
    .bram_do (bram_do),
    .w_data  (w_data),
    .w_valid (w_valid),
    .w_ready (w_ready),
    .w_last  (w_last)
`ifdef WEIGHT_RD_LOAD_EN
    ,
    .load    (load),
    .ld_data (ld_data),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready)
`endif
  );

  always #5 clk = ~clk;

  // Single-port BRAM clocked on the falling edge.
  logic [DW-1:0] mem [DEPTH];
  logic          preloaded = 1'b0;
  always @(negedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 16'(i - 14);
      preloaded <= 1'b1;
      bram_do   <= '0;
    end else if (en && (addr < AW'(DEPTH))) begin
      if (we) mem[addr] <= di;
      else    bram_do   <= mem[addr];
    end
  end

  int            checks = 0;
  int            failures = 0;
  weight_entry_t exp_q[$];
  logic [DW-1:0] exp_words [DEPTH];
  int            rdy_mode = 0;
  int            cyc = 0;
  int            done_cnt = 0;
  int            beat_cnt = 0;
  int            we_cnt = 0;
  int            start_cyc = 0;
  int            last_hs_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_addr"},    32'(addr), 0);
    chk({tag, "_en"},      32'(en), 0);
    chk({tag, "_we"},      32'(we), 0);
    chk({tag, "_di"},      32'(di), 0);
    chk({tag, "_w_data"},  32'(w_data), 0);
    chk({tag, "_w_valid"}, 32'(w_valid), 0);
    chk({tag, "_w_last"},  32'(w_last), 0);
    chk({tag, "_busy"},    32'(busy), 0);
    chk({tag, "_done"},    32'(done), 0);
  endtask

  // Pulse START for one cycle and queue the words the pass must deliver.
  task automatic issue_start();
    weight_entry_t e;
    for (int i = 0; i < DEPTH; i++) begin
      e.data = exp_words[i];
      e.last = (i == DEPTH - 1);
      exp_q.push_back(e);
    end
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cycles);
    int base;
    int n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk({name, "_done_seen"}, 32'(done_cnt != base), 1);
  endtask

  // Backpressure pattern 1,0,0,1 when rdy_mode=1, otherwise always ready.
  initial begin : ready_driver
    int phase;
    phase = 0;
    w_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) w_ready = (phase == 0 || phase == 3);
      else               w_ready = 1'b1;
      phase = (phase + 1) % 4;
    end
  end

  initial begin : monitor
    weight_entry_t e;
    logic          hs, rd;
    logic          prev_stall, prev_last_hs, prev_ld_last, resume_exp;
    logic [DW-1:0] prev_data;
    logic          prev_lastbit;
    int            model_cnt, reads;
    model_cnt = 0; reads = 0;
    prev_stall = 0; prev_last_hs = 0; prev_ld_last = 0; resume_exp = 0;
    prev_data = '0; prev_lastbit = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        model_cnt = 0; reads = 0;
        prev_stall = 0; prev_last_hs = 0; prev_ld_last = 0; resume_exp = 0;
      end else begin
        hs = w_valid && w_ready;
        rd = en && !we;
        if (prev_stall) begin
          chk("stall_valid", 32'(w_valid), 1);
          chk("stall_data", 32'(w_data), 32'(prev_data));
          chk("stall_last", 32'(w_last), 32'(prev_lastbit));
        end
        chk("done_timing", 32'(done), 32'(prev_last_hs || prev_ld_last));
        if (done) done_cnt++;
        if (en) chk("addr_range", 32'(addr < AW'(DEPTH)), 1);
        if (model_cnt == 2) chk("en_when_full", 32'(en), 0);
        if (resume_exp) chk("read_resume", 32'(en), 1);
`ifndef WEIGHT_RD_LOAD_EN
        chk("we_zero", 32'(we), 0);
        chk("di_zero", 32'(di), 0);
`endif
        if (start && !busy) begin
          start_cyc = cyc;
          reads = 0;
        end
        if (hs) begin
          beat_cnt++;
          if (w_last) last_hs_cyc = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_beat: got data=%0h last=%0b required no beat", w_data, w_last);
          end else begin
            e = exp_q.pop_front();
            $display("beat %0d: data=%0h last=%0b expected data=%0h last=%0b",
                     beat_cnt, w_data, w_last, e.data, e.last);
            chk("beat_data", 32'(w_data), 32'(e.data));
            chk("beat_last", 32'(w_last), 32'(e.last));
          end
        end
        prev_ld_last = 1'b0;
        if (we) begin
          we_cnt++;
          prev_ld_last = ((we_cnt % DEPTH) == 0);
        end
        resume_exp = (model_cnt == 2) && hs && (reads < DEPTH);
        reads      = reads + int'(rd);
        model_cnt  = model_cnt + int'(rd) - int'(hs);
        prev_stall   = w_valid && !w_ready;
        prev_data    = w_data;
        prev_lastbit = w_last;
        prev_last_hs = hs && w_last;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int base_done;
    int base_beats;
    int n;
    rst_n = 1'b0;
    start = 1'b0;
`ifdef WEIGHT_RD_LOAD_EN
    load = 1'b0;
    ld_data = '0;
    ld_valid = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) exp_words[i] = 16'(i - 14);

    repeat (3) @(posedge clk);
    #1 check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Free-running pass: EN the cycle after START, W_VALID one cycle later.
    rdy_mode = 0;
    issue_start();
    @(negedge clk);
    chk("first_en", 32'(en), 1);
    chk("first_addr", 32'(addr), 0);
    chk("first_busy", 32'(busy), 1);
    chk("first_valid_low", 32'(w_valid), 0);
    @(negedge clk);
    chk("first_valid_high", 32'(w_valid), 1);
    wait_done("pass1", 100);
    // START cycle through W_LAST cycle inclusive spans DEPTH+2 cycles.
    chk("pass1_latency", 32'(last_hs_cyc - start_cyc), 32'(DEPTH + 1));
    chk("pass1_queue_empty", 32'(exp_q.size()), 0);
    chk("pass1_idle", 32'(busy), 0);

    // Backpressure with W_READY cycling 1,0,0,1.
    repeat (2) @(posedge clk);
    #1 rdy_mode = 1;
    issue_start();
    wait_done("backpressure", 300);
    chk("bp_queue_empty", 32'(exp_q.size()), 0);
    rdy_mode = 0;

    // Second START while busy must be ignored.
    repeat (2) @(posedge clk);
    #1 base_done = done_cnt;
    issue_start();
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("restart_busy", 100);
    repeat (10) @(posedge clk);
    #1;
    chk("restart_one_done", 32'(done_cnt - base_done), 1);
    chk("restart_queue_empty", 32'(exp_q.size()), 0);
    chk("restart_idle_valid", 32'(w_valid), 0);

    // Reset after beat 10 aborts the pass; a new START begins at address 0.
    base_beats = beat_cnt;
    base_done = done_cnt;
    issue_start();
    n = 0;
    while ((beat_cnt - base_beats) < 10 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("abort_reached_beat10", 32'((beat_cnt - base_beats) >= 10), 1);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1 check_reset_vals("abort");
    repeat (3) @(posedge clk);
    #1 check_reset_vals("abort_hold");
    chk("abort_no_done", 32'(done_cnt - base_done), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 issue_start();
    @(negedge clk);
    chk("after_abort_addr", 32'(addr), 0);
    wait_done("after_abort", 100);
    chk("after_abort_queue_empty", 32'(exp_q.size()), 0);

`ifdef WEIGHT_RD_LOAD_EN
    // Load alternating extremes, then read them back.
    repeat (2) @(posedge clk);
    #1 base_done = done_cnt;
    we_cnt = 0;
    start = 1'b1;
    load = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    load = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      ld_valid = 1'b1;
      ld_data = (k % 2 == 0) ? 16'h7FFF : 16'h8000;
      @(negedge clk);
      chk("ld_ready", 32'(ld_ready), 1);
      @(posedge clk);
      #1;
    end
    ld_valid = 1'b0;
    wait_done("load", 20);
    chk("load_we_cycles", 32'(we_cnt), 32'(DEPTH));
    for (int k = 0; k < DEPTH; k++) exp_words[k] = (k % 2 == 0) ? 16'h7FFF : 16'h8000;
    repeat (2) @(posedge clk);
    #1 issue_start();
    wait_done("load_readback", 100);
    chk("load_readback_queue_empty", 32'(exp_q.size()), 0);
    chk("load_we_total", 32'(we_cnt), 32'(DEPTH));
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
